// File: rtl/ksa_nibble_serial_adder.sv
// Nibble-serial WIDTH-bit adder: one 4-bit Kogge-Stone step per clock, LSB nibble first,
// with the carry chained through a register between steps.

module ksa_4bit_df (
    input  logic [3:0] A,
    input  logic [3:0] B,
    output logic [3:0] S,
    output logic       Cout
);
    logic [3:0] g0, p0, g1, g2;
    logic [3:2] p1;

    assign g0 = A & B;
    assign p0 = A ^ B;

    // Prefix level 1 (span 1) and level 2 (span 2)
    assign g1[0]   = g0[0];
    assign g1[3:1] = g0[3:1] | (p0[3:1] & g0[2:0]);
    assign p1[3:2] = p0[3:2] & p0[2:1];

    assign g2[1:0] = g1[1:0];
    assign g2[3:2] = g1[3:2] | (p1[3:2] & g1[1:0]);

    assign S[0]   = p0[0];
    assign S[3:1] = p0[3:1] ^ g2[2:0];
    assign Cout   = g2[3];
endmodule

module ksa_nibble_serial_adder #(
    parameter int unsigned WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);
    localparam int unsigned NIBBLES = WIDTH / 4;
    localparam int unsigned CW      = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;

    typedef enum logic {IDLE, ADD} state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_sh, b_sh, res, res_d;
    logic [CW-1:0]    cnt;
    logic             carry_q, carry_d;
    logic             last;
    logic [3:0]       add_s, nib_s;
    logic             add_c, cin_c;

    ksa_4bit_df u_add (
        .A    (a_sh[3:0]),
        .B    (b_sh[3:0]),
        .S    (add_s),
        .Cout (add_c)
    );

    ksa_4bit_df u_cin (
        .A    (add_s),
        .B    ({3'b000, carry_q}),
        .S    (nib_s),
        .Cout (cin_c)
    );

    // At most one of the two stage carries can be set in a given cycle
    assign carry_d = add_c | cin_c;
    assign last    = (cnt == CW'(NIBBLES - 1));

    generate
        if (WIDTH > 4) begin : g_res_wide
            assign res_d = {nib_s, res[WIDTH-1:4]};
        end else begin : g_res_nib
            assign res_d = nib_s;
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = ADD;
            ADD:     if (last)  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        busy = (state_q == ADD);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            a_sh    <= '0;
            b_sh    <= '0;
            res     <= '0;
            cnt     <= '0;
            carry_q <= 1'b0;
            sum     <= '0;
            cout    <= 1'b0;
            done    <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        a_sh    <= a;
                        b_sh    <= b;
                        carry_q <= cin;
                        cnt     <= '0;
                    end
                end
                ADD: begin
                    a_sh    <= a_sh >> 4;
                    b_sh    <= b_sh >> 4;
                    res     <= res_d;
                    carry_q <= carry_d;
                    cnt     <= cnt + CW'(1);
                    if (last) begin
                        sum  <= res_d;
                        cout <= carry_d;
                        done <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule
